// File: rtl/object_fetch_scheduler.sv
// object_fetch_scheduler: walks a small object table once per frame and issues one fetch job per enabled object.
// Define OBJ_SCHED_TIMEOUT_EN to build the WAIT-state watchdog (abort_out / timeout_err_out); otherwise both are tied low.

module object_fetch_scheduler #(
  parameter int MAX_OBJS       = 8,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int ID_W          = (MAX_OBJS > 1) ? $clog2(MAX_OBJS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic              cfg_we_in,
  input  logic [ID_W-1:0]   cfg_addr_in,
  input  logic [2*ADDR_W:0] cfg_data_in,
  output logic              fetch_start_out,
  output logic [ADDR_W-1:0] facet_base_out,
  output logic [ADDR_W-1:0] facet_count_out,
  output logic [ID_W-1:0]   obj_id_out,
  input  logic              fetch_done_in,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              overrun_out,
  output logic              abort_out,
  output logic              timeout_err_out
);

  localparam int IDX_W = $clog2(MAX_OBJS + 1);

  if (MAX_OBJS < 1 || MAX_OBJS > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("object_fetch_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [ID_W-1:0]   idx_lo;
  logic              idx_end;
  logic              entry_valid;
  logic              load_job;
  logic              wd_expire;
  logic              wd_abort;

  logic              en_tab    [MAX_OBJS];
  logic [ADDR_W-1:0] base_tab  [MAX_OBJS];
  logic [ADDR_W-1:0] count_tab [MAX_OBJS];

  // Object table: plain flops, so a SCAN reading an entry being written this cycle sees the old value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < MAX_OBJS; i++) begin
        en_tab[i]    <= 1'b0;
        base_tab[i]  <= '0;
        count_tab[i] <= '0;
      end
    end else if (cfg_we_in && (int'(cfg_addr_in) < MAX_OBJS)) begin
      en_tab[cfg_addr_in]    <= cfg_data_in[2*ADDR_W];
      base_tab[cfg_addr_in]  <= cfg_data_in[2*ADDR_W-1:ADDR_W];
      count_tab[cfg_addr_in] <= cfg_data_in[ADDR_W-1:0];
    end
  end

  assign idx_lo      = idx[ID_W-1:0];
  assign idx_end     = (int'(idx) >= MAX_OBJS);
  assign entry_valid = !idx_end && en_tab[idx_lo] && (count_tab[idx_lo] != '0);

`ifdef OBJ_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Counter holds 0 on the first WAIT cycle, so the limit is hit on WAIT cycle number TIMEOUT_CYCLES.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wd_cnt          <= '0;
      timeout_err_out <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wd_cnt <= '0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (wd_abort) begin
        timeout_err_out <= 1'b1;
      end
    end
  end

  assign wd_expire = (state == S_WAIT) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign abort_out = wd_abort;
`else
  assign wd_expire       = 1'b0;
  assign abort_out       = 1'b0;
  assign timeout_err_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_job  = 1'b0;
    wd_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start_in) begin
          state_nxt = S_SCAN;
          idx_nxt   = '0;
        end
      end
      S_SCAN: begin
        if (idx_end) begin
          state_nxt = S_DONE;
        end else if (entry_valid) begin
          load_job  = 1'b1;
          state_nxt = S_ISSUE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle takes priority over the abort.
        if (fetch_done_in) begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_SCAN;
        end else if (wd_expire) begin
          wd_abort  = 1'b1;
          idx_nxt   = idx + 1'b1;
          state_nxt = S_SCAN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Job registers hold their value until the next issue, decoupling them from later table writes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      idx             <= '0;
      facet_base_out  <= '0;
      facet_count_out <= '0;
      obj_id_out      <= '0;
      overrun_out     <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (load_job) begin
        facet_base_out  <= base_tab[idx_lo];
        facet_count_out <= count_tab[idx_lo];
        obj_id_out      <= idx_lo;
      end
      if (frame_start_in && (state != S_IDLE)) begin
        overrun_out <= 1'b1;
      end
    end
  end

  assign fetch_start_out = (state == S_ISSUE);
  assign frame_done_out  = (state == S_DONE);
  assign busy_out        = (state != S_IDLE);

endmodule
